// File: rtl/grf_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grf_mp_pkg
// Description : Shared defaults and constants for the multi-port general
//               register file and its pending-bit scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package grf_mp_pkg;

    // Default geometry of the register file
    localparam int c_DW_DEFAULT = 32;
    localparam int c_AW_DEFAULT = 5;

    // Index of the hardwired zero register
    localparam int c_REG_ZERO = 0;

    // Trace format for register writes: port, address, data
    localparam string c_WR_FMT = "WR port%0d r%0d <= %08h";

endpackage : grf_mp_pkg
`default_nettype wire

// File: rtl/grf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : grf_scoreboard
// Description : Per-register pending bits. An issue sets a bit and an
//               effective write clears it. Also provides the per-read-port
//               busy lookup used by the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_scoreboard
    import grf_mp_pkg::*;
#(
    parameter int AW       = c_AW_DEFAULT,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iss,
    input  logic [AW-1:0]       iss_a,
    input  logic                wv0,
    input  logic [AW-1:0]       wa0,
    input  logic                wv1,
    input  logic [AW-1:0]       wa1,
    input  logic [NR*AW-1:0]    ra,
    output logic [NR-1:0]       busy,
    output logic [(2**AW)-1:0]  pend
);

    localparam int c_DEPTH = 2 ** AW;

    logic [c_DEPTH-1:0] r_pend;
    logic [c_DEPTH-1:0] w_pend_nxt;

    // Next pending vector: an issue wins over a write to the same register,
    // because the issuing instruction is the younger producer.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int r = 0; r < c_DEPTH; r++) begin
            if (iss && (iss_a == AW'(r))) begin
                w_pend_nxt[r] = 1'b1;
            end else if ((wv0 && (wa0 == AW'(r))) || (wv1 && (wa1 == AW'(r)))) begin
                w_pend_nxt[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            w_pend_nxt[c_REG_ZERO] = 1'b0;
        end
    end

    // Pending register; reset discards all in-flight producers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign pend = r_pend;

    // A write landing this cycle is forwarded by the bypass, so it cancels busy
    for (genvar k = 0; k < NR; k++) begin : g_busy
        logic [AW-1:0] w_ra;
        assign w_ra    = ra[k*AW +: AW];
        assign busy[k] = r_pend[w_ra]
                         && !(wv0 && (wa0 == w_ra))
                         && !(wv1 && (wa1 == w_ra));
    end

endmodule : grf_scoreboard
`default_nettype wire

// File: rtl/grf_mp.sv
`default_nettype none
// ============================================================================
// Module      : grf_mp
// Description : Parametrised general register file with NR combinational
//               read ports, two prioritised write ports, write-through bypass,
//               optional hardwired zero register and integrated pending bits.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_mp
    import grf_mp_pkg::*;
#(
    parameter int DW       = c_DW_DEFAULT,
    parameter int AW       = c_AW_DEFAULT,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NR*AW-1:0]    ra,
    output logic [NR*DW-1:0]    rd,
    output logic [NR-1:0]       busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [DW-1:0]       wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [DW-1:0]       wd1,
    input  logic                iss,
    input  logic [AW-1:0]       iss_a,
    output logic [(2**AW)-1:0]  pend
);

    localparam int            c_DEPTH = 2 ** AW;
    localparam logic [AW-1:0] c_ZADDR = AW'(c_REG_ZERO);
    localparam bit            c_ZERO  = (ZERO_REG != 0);

    logic [DW-1:0] r_mem [c_DEPTH];
    logic          w_we0_eff;
    logic          w_we1_eff;

    // A write to the zero register is not a write at all
    assign w_we0_eff = we0 && !(c_ZERO && (wa0 == c_ZADDR));
    assign w_we1_eff = we1 && !(c_ZERO && (wa1 == c_ZADDR));

    // Storage update; port 1 is assigned last so it wins an address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we0_eff) begin
                r_mem[wa0] <= wd0;
            end
            if (w_we1_eff) begin
                r_mem[wa1] <= wd1;
            end
        end
    end

    // Per-port read mux: zero register, then port 1, then port 0, then storage
    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic [DW-1:0] w_rd;
        assign w_ra = ra[k*AW +: AW];

        // Bypass selection for this read port
        always_comb begin
            w_rd = r_mem[w_ra];
            if (w_we0_eff && (wa0 == w_ra)) begin
                w_rd = wd0;
            end
            if (w_we1_eff && (wa1 == w_ra)) begin
                w_rd = wd1;
            end
            if (c_ZERO && (w_ra == c_ZADDR)) begin
                w_rd = '0;
            end
        end

        assign rd[k*DW +: DW] = w_rd;
    end

    grf_scoreboard #(
        .AW       (AW),
        .NR       (NR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk   (clk),
        .reset (reset),
        .iss   (iss),
        .iss_a (iss_a),
        .wv0   (w_we0_eff),
        .wa0   (wa0),
        .wv1   (w_we1_eff),
        .wa1   (wa1),
        .ra    (ra),
        .busy  (busy),
        .pend  (pend)
    );

endmodule : grf_mp
`default_nettype wire
